obi_reg_arb_bridge: RTL and testbench

- Parametrised successor to the single-port OBI-to-register conversion plus fixed two-port register mux in the system bus.
- Accepts NIN independent OBI slave ports and arbitrates them round-robin onto one register-interface master port (e.g. the wrapper CSR block).
- One transaction outstanding at a time.
- Adds a response timeout and error reporting, which the current path lacks.

---
 rtl/obi_reg_arb_bridge_pkg.sv | 42 ++++
 rtl/obi_reg_arb_bridge_rr_arbiter.sv | 49 ++++
 rtl/obi_reg_arb_bridge.sv | 129 ++++++++++++
 tb/tb_obi_reg_arb_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_reg_arb_bridge_pkg.sv
// Shared types and constants for the OBI-to-register arbitrating bridge.
// Bus structs are packed so they can be carried as flat vectors between blocks.
package obi_reg_arb_bridge_pkg;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;
  localparam int          DEFAULT_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/obi_reg_arb_bridge_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant/index searching upward from ptr;
// ptr moves past the winner when advance is asserted. No internal backpressure.
module obi_reg_arb_bridge_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  generate
    if (N == 1) begin : g_single
      assign ptr = '0;
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) begin
          ptr <= '0;
        end else if (advance && any) begin
          ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/obi_reg_arb_bridge.sv
// Round-robin bridge from NIN OBI slave ports onto one register master; one access in flight.
// gnt at T, reg valid from T+1, rvalid earliest at T+2; requesters wait by holding req.
module obi_reg_arb_bridge
  import obi_reg_arb_bridge_pkg::*;
#(
  parameter int          NIN            = 2,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter int          IDW            = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  obi_req_t  [NIN-1:0]  obi_req_i,
  output obi_resp_t [NIN-1:0]  obi_resp_o,
  output reg_req_t             reg_req_o,
  input  reg_rsp_t             reg_rsp_i,
  output logic                 err_valid_o,
  output logic [IDW-1:0]       err_id_o,
  output logic                 err_timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t          state;
  logic [CW-1:0]   cnt;
  reg_req_t        reg_q;
  logic [IDW-1:0]  owner;
  logic [31:0]     rdata_q;
  logic            rvld_q;
  logic            err_vld_q;
  logic            err_to_q;

  logic [NIN-1:0]  req_vec;
  logic [NIN-1:0]  arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            grant;

  always_comb begin
    for (int i = 0; i < NIN; i++) req_vec[i] = obi_req_i[i].req;
  end

  // Grants are suppressed during reset so no requester sees a gnt that is then discarded.
  assign grant = (state == IDLE) && !rst_i && arb_any;

  obi_reg_arb_bridge_rr_arbiter #(
    .N  (NIN),
    .IW (IDW)
  ) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req_vec),
    .advance (grant),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      reg_q     <= '0;
      owner     <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      err_vld_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            reg_q.valid <= 1'b1;
            reg_q.write <= obi_req_i[arb_idx].we;
            reg_q.addr  <= obi_req_i[arb_idx].addr;
            reg_q.wdata <= obi_req_i[arb_idx].wdata;
            reg_q.wstrb <= obi_req_i[arb_idx].be;
            owner       <= arb_idx;
            cnt         <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
          // A ready arriving on the timeout cycle still completes normally.
          if (reg_rsp_i.ready) begin
            reg_q     <= '0;
            rvld_q    <= 1'b1;
            rdata_q   <= reg_q.write ? 32'h0 : (reg_rsp_i.error ? ERR_RDATA : reg_rsp_i.rdata);
            err_vld_q <= reg_rsp_i.error;
            err_to_q  <= 1'b0;
            state     <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            reg_q     <= '0;
            rvld_q    <= 1'b1;
            rdata_q   <= ERR_RDATA;
            err_vld_q <= 1'b1;
            err_to_q  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rvld_q    <= 1'b0;
          err_vld_q <= 1'b0;
          err_to_q  <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      obi_resp_o[i].gnt    = grant && arb_gnt[i];
      obi_resp_o[i].rvalid = rvld_q && (owner == IDW'(i));
      obi_resp_o[i].rdata  = (rvld_q && (owner == IDW'(i))) ? rdata_q : 32'h0;
    end
  end

  assign reg_req_o     = reg_q;
  assign err_valid_o   = err_vld_q;
  assign err_id_o      = (NIN > 1) ? owner : '0;
  assign err_timeout_o = err_to_q;

endmodule

// File: tb/tb_obi_reg_arb_bridge.sv
// Directed bench for obi_reg_arb_bridge with NIN=4 and a short timeout of 4 cycles.
module tb_obi_reg_arb_bridge;
  import obi_reg_arb_bridge_pkg::*;

  logic             clk;
  logic             rst;
  obi_req_t  [3:0]  obi_req;
  obi_resp_t [3:0]  obi_resp;
  reg_req_t         reg_req;
  reg_rsp_t         reg_rsp;
  logic             err_valid;
  logic [1:0]       err_id;
  logic             err_timeout;

  int total = 0;
  int bad   = 0;

  obi_reg_arb_bridge #(
    .NIN            (4),
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hBADCAB1E)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .obi_req_i     (obi_req),
    .obi_resp_o    (obi_resp),
    .reg_req_o     (reg_req),
    .reg_rsp_i     (reg_rsp),
    .err_valid_o   (err_valid),
    .err_id_o      (err_id),
    .err_timeout_o (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // One zero-wait write transaction; caller has requests driven and settled in IDLE.
  task automatic serve(input int p);
    for (int i = 0; i < 4; i++) chk($sformatf("serve%0d gnt%0d", p, i), obi_resp[i].gnt, (i == p));
    tick();
    chk($sformatf("serve%0d valid", p), reg_req.valid, 1);
    chk($sformatf("serve%0d wdata", p), reg_req.wdata, 32'hA + p);
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("serve%0d rvalid%0d", p, i), obi_resp[i].rvalid, (i == p));
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    obi_req = '0;
    reg_rsp = '0;
    tick();
    tick();
    chk("rst valid", reg_req.valid, 0);
    chk("rst addr", reg_req.addr, 0);
    chk("rst err_valid", err_valid, 0);
    chk("rst err_id", err_id, 0);
    chk("rst err_timeout", err_timeout, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst rvalid%0d", i), obi_resp[i].rvalid, 0);
    rst = 1'b0;
    settle();

    // Single zero-wait read on port 0.
    reg_rsp.ready = 1'b1;
    reg_rsp.rdata = 32'hCAFE0001;
    reg_rsp.error = 1'b0;
    obi_req[0].req  = 1'b1;
    obi_req[0].we   = 1'b0;
    obi_req[0].addr = 32'h10;
    obi_req[0].be   = 4'hF;
    settle();
    chk("rd gnt0", obi_resp[0].gnt, 1);
    chk("rd gnt1", obi_resp[1].gnt, 0);
    tick();
    obi_req[0].req = 1'b0;
    settle();
    chk("rd valid", reg_req.valid, 1);
    chk("rd write", reg_req.write, 0);
    chk("rd addr", reg_req.addr, 32'h10);
    chk("rd gnt0 access", obi_resp[0].gnt, 0);
    tick();
    chk("rd rvalid0", obi_resp[0].rvalid, 1);
    chk("rd rdata0", obi_resp[0].rdata, 32'hCAFE0001);
    chk("rd rvalid1", obi_resp[1].rvalid, 0);
    chk("rd err_valid", err_valid, 0);
    tick();
    chk("rd rvalid0 drop", obi_resp[0].rvalid, 0);

    // Ports 0 and 1 writing continuously alternate from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      obi_req[i].we    = 1'b1;
      obi_req[i].be    = 4'hF;
      obi_req[i].wdata = 32'hA + i;
      obi_req[i].addr  = 32'h20 + 4 * i;
    end
    obi_req[0].req = 1'b1;
    obi_req[1].req = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) serve(k % 2);
    obi_req[0].req = 1'b0;
    obi_req[1].req = 1'b0;
    settle();

    // Timeout on a port-1 read with a slave that never answers.
    reg_rsp.ready  = 1'b0;
    obi_req[1].we  = 1'b0;
    obi_req[1].req = 1'b1;
    settle();
    chk("to gnt1", obi_resp[1].gnt, 1);
    tick();
    obi_req[1].req = 1'b0;
    settle();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to valid c%0d", c), reg_req.valid, 1);
      tick();
    end
    chk("to rvalid1", obi_resp[1].rvalid, 1);
    chk("to rdata1", obi_resp[1].rdata, 32'hBADCAB1E);
    chk("to rvalid0", obi_resp[0].rvalid, 0);
    chk("to err_valid", err_valid, 1);
    chk("to err_id", err_id, 1);
    chk("to err_timeout", err_timeout, 1);
    chk("to valid dropped", reg_req.valid, 0);
    tick();
    chk("to err_valid drop", err_valid, 0);
    chk("to rvalid1 drop", obi_resp[1].rvalid, 0);

    // Slave error on a port-0 read.
    reg_rsp.ready  = 1'b1;
    reg_rsp.error  = 1'b1;
    reg_rsp.rdata  = 32'h12345678;
    obi_req[0].we  = 1'b0;
    obi_req[0].req = 1'b1;
    settle();
    chk("se gnt0", obi_resp[0].gnt, 1);
    tick();
    obi_req[0].req = 1'b0;
    tick();
    chk("se rvalid0", obi_resp[0].rvalid, 1);
    chk("se rdata0", obi_resp[0].rdata, 32'hBADCAB1E);
    chk("se err_valid", err_valid, 1);
    chk("se err_timeout", err_timeout, 0);
    chk("se err_id", err_id, 0);
    tick();

    // Ready arriving on the timeout cycle wins, port 2.
    reg_rsp.ready  = 1'b0;
    reg_rsp.error  = 1'b0;
    reg_rsp.rdata  = 32'h55AA55AA;
    obi_req[2].we  = 1'b0;
    obi_req[2].req = 1'b1;
    settle();
    chk("rt gnt2", obi_resp[2].gnt, 1);
    tick();
    obi_req[2].req = 1'b0;
    tick();
    tick();
    tick();
    reg_rsp.ready = 1'b1;
    settle();
    tick();
    chk("rt rvalid2", obi_resp[2].rvalid, 1);
    chk("rt rdata2", obi_resp[2].rdata, 32'h55AA55AA);
    chk("rt err_valid", err_valid, 0);
    tick();

    // Reset during ACCESS abandons the access and resets the pointer.
    reg_rsp.ready  = 1'b0;
    obi_req[1].req = 1'b1;
    settle();
    chk("ra gnt1", obi_resp[1].gnt, 1);
    tick();
    obi_req[1].req = 1'b0;
    settle();
    chk("ra valid", reg_req.valid, 1);
    rst = 1'b1;
    tick();
    chk("ra valid in rst", reg_req.valid, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("ra rvalid%0d", i), obi_resp[i].rvalid, 0);
    rst = 1'b0;
    tick();
    chk("ra rvalid1 after", obi_resp[1].rvalid, 0);
    chk("ra valid after", reg_req.valid, 0);
    reg_rsp.ready = 1'b1;
    for (int i = 0; i < 4; i++) obi_req[i].we = 1'b1;
    obi_req[0].req = 1'b1;
    obi_req[2].req = 1'b1;
    settle();
    serve(0);

    // Ports 1 and 3 after a grant to 1, then all four rotating.
    obi_req[0].req = 1'b0;
    obi_req[2].req = 1'b0;
    obi_req[1].req = 1'b1;
    obi_req[3].req = 1'b1;
    settle();
    serve(1);
    serve(3);
    serve(1);
    obi_req[0].req = 1'b1;
    obi_req[2].req = 1'b1;
    settle();
    serve(2);
    serve(3);
    serve(0);
    serve(1);
    obi_req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
